// File: rtl/xbar_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Package     : xbar_cfg_pkg
// Description : Shared constants and types for the crossbar config loader.
//               The crossbar has NUM_OUT outputs, and each output has a SEL_W-bit
//               select field. The full configuration arrives as NUM_WORDS
//               stream words of WORD_W bits each.
// Revision    : 1.0 - initial release
// ============================================================================
package xbar_cfg_pkg;

    localparam int unsigned NUM_IN     = 19;
    localparam int unsigned NUM_OUT    = 24;
    localparam int unsigned SEL_W      = 5;
    localparam int unsigned WORD_W     = 8;
    localparam int unsigned CFG_W      = NUM_OUT * SEL_W;
    localparam int unsigned NUM_WORDS  = CFG_W / WORD_W;
    localparam int unsigned WORD_CNT_W = $clog2(NUM_WORDS);
    localparam int unsigned CHK_IDX_W  = $clog2(NUM_OUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        CHECK  = 2'd2,
        COMMIT = 2'd3
    } cfg_state_t;

    typedef logic [WORD_CNT_W-1:0] cfg_word_cnt_t;
    typedef logic [CHK_IDX_W-1:0]  cfg_chk_idx_t;

endpackage
`default_nettype wire

// File: rtl/xbar_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module      : xbar_cfg_loader
// Description : Assembles a crossbar select configuration from a word stream
//               into a staging register. It then range-checks one select field
//               per cycle. A configuration is committed to io_mux_configs in a
//               single cycle only when every field is legal, so the crossbar
//               never sees a partial or illegal configuration.
// Ports       : clk, reset (sync, active-low)
//               io_cfg_start   - begin/restart a load
//               io_cfg_valid / io_cfg_ready / io_cfg_data - word stream
//               io_mux_configs - active configuration to the crossbar
//               io_cfg_done    - one-cycle pulse when a configuration commits
//               io_cfg_err     - sticky: last load had an illegal select
//               io_busy        - loader is not idle
// Revision    : 1.0 - initial release
// ============================================================================
module xbar_cfg_loader
    import xbar_cfg_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              io_cfg_start,
    input  logic              io_cfg_valid,
    output logic              io_cfg_ready,
    input  logic [WORD_W-1:0] io_cfg_data,
    output logic [CFG_W-1:0]  io_mux_configs,
    output logic              io_cfg_done,
    output logic              io_cfg_err,
    output logic              io_busy
);

    generate
        if ((CFG_W % WORD_W) != 0) begin : g_bad_word_w
            $error("CFG_W must be a whole number of WORD_W words");
        end
    endgenerate

    localparam logic [SEL_W-1:0]  c_sel_limit = SEL_W'(NUM_IN);
    localparam cfg_word_cnt_t     c_word_last = cfg_word_cnt_t'(NUM_WORDS - 1);
    localparam cfg_chk_idx_t      c_chk_last  = cfg_chk_idx_t'(NUM_OUT - 1);

    cfg_state_t        r_state;
    cfg_state_t        w_next_state;
    logic [CFG_W-1:0]  r_staging;
    logic [CFG_W-1:0]  r_mux_configs;
    cfg_word_cnt_t     r_word_cnt;
    cfg_chk_idx_t      r_chk_idx;
    logic              r_bad;        // some field already checked was illegal
    logic              r_ready;
    logic              r_done;
    logic              r_err;
    logic              r_busy;

    logic              w_handshake;
    logic              w_restart;
    logic              w_check_last;
    logic              w_field_bad;

    // Field under test is selected by the check index. The state machine only
    // acts on w_field_bad while it is in CHECK.
    assign w_field_bad = (r_staging[SEL_W*32'(r_chk_idx) +: SEL_W] >= c_sel_limit);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_handshake  = 1'b0;
        w_restart    = 1'b0;
        w_check_last = 1'b0;
        case (r_state)
            IDLE: begin
                if (io_cfg_start) begin
                    w_next_state = LOAD;
                end
            end
            LOAD: begin
                // Restart takes priority; any word that arrives in the same cycle is dropped.
                if (io_cfg_start) begin
                    w_restart = 1'b1;
                end else if (io_cfg_valid) begin
                    w_handshake = 1'b1;
                    if (r_word_cnt == c_word_last) begin
                        w_next_state = CHECK;
                    end
                end
            end
            CHECK: begin
                if (r_chk_idx == c_chk_last) begin
                    w_check_last = 1'b1;
                    w_next_state = (r_bad || w_field_bad) ? IDLE : COMMIT;
                end
            end
            COMMIT: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_staging     <= '0;
            r_mux_configs <= '0;
            r_word_cnt    <= '0;
            r_chk_idx     <= '0;
            r_bad         <= 1'b0;
            r_ready       <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            // Handshake outputs are registered from the next state, so they
            // line up with the state that the loader is in.
            r_ready <= (w_next_state == LOAD);
            r_done  <= (w_next_state == COMMIT);
            r_busy  <= (w_next_state != IDLE);

            if ((r_state == IDLE) && io_cfg_start) begin
                r_word_cnt <= '0;
                r_staging  <= '0;
                r_err      <= 1'b0;
            end

            if (w_restart) begin
                r_word_cnt <= '0;
                r_staging  <= '0;
            end

            if (w_handshake) begin
                r_staging[WORD_W*32'(r_word_cnt) +: WORD_W] <= io_cfg_data;
                r_word_cnt <= r_word_cnt + cfg_word_cnt_t'(1);
                r_chk_idx  <= '0;
                r_bad      <= 1'b0;
            end

            if (r_state == CHECK) begin
                r_chk_idx <= r_chk_idx + cfg_chk_idx_t'(1);
                r_bad     <= r_bad | w_field_bad;
                if (w_check_last && (r_bad || w_field_bad)) begin
                    r_err <= 1'b1;
                end
            end

            if (r_state == COMMIT) begin
                r_mux_configs <= r_staging;
            end
        end
    end

    assign io_cfg_ready   = r_ready;
    assign io_cfg_done    = r_done;
    assign io_cfg_err     = r_err;
    assign io_busy        = r_busy;
    assign io_mux_configs = r_mux_configs;

endmodule
`default_nettype wire

// File: tb/tb_xbar_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_xbar_cfg_loader
// Description : Self-checking bench for xbar_cfg_loader. The bench applies a
//               table of configuration loads, and each entry states the
//               expected outcome. Expected commit results go through a
//               scoreboard queue. Hand-written sequences cover a reset during
//               LOAD and a reset during CHECK.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xbar_cfg_loader;
    import xbar_cfg_pkg::*;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              io_cfg_start = 1'b0;
    logic              io_cfg_valid = 1'b0;
    logic              io_cfg_ready;
    logic [WORD_W-1:0] io_cfg_data = '0;
    logic [CFG_W-1:0]  io_mux_configs;
    logic              io_cfg_done;
    logic              io_cfg_err;
    logic              io_busy;

    xbar_cfg_loader dut (
        .clk            (clk),
        .reset          (reset),
        .io_cfg_start   (io_cfg_start),
        .io_cfg_valid   (io_cfg_valid),
        .io_cfg_ready   (io_cfg_ready),
        .io_cfg_data    (io_cfg_data),
        .io_mux_configs (io_mux_configs),
        .io_cfg_done    (io_cfg_done),
        .io_cfg_err     (io_cfg_err),
        .io_busy        (io_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [CFG_W-1:0] cfg;
        bit               gaps;
        int               restart_after;  // 0 = no restart
        int               inject_n;       // cycle after last handshake to pulse start, 0 = none
        bit               exp_ok;
    } vec_t;

    typedef struct packed {
        logic             ok;
        logic [CFG_W-1:0] mux;
    } exp_t;

    localparam int NVEC = 7;

    int               total = 0;
    int               bad   = 0;
    int               t_hs  = 0;    // cyc value seen right after the final handshake
    logic [CFG_W-1:0] model_mux = '0;
    vec_t             vecs [NVEC];
    exp_t             sb_q [$];

    task automatic chk(input string name, input logic [CFG_W-1:0] act, input logic [CFG_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // In field k, the select value is (k*mul + add) % NUM_IN. Every value is legal.
    function automatic logic [CFG_W-1:0] pattern(input int mul, input int add);
        logic [CFG_W-1:0] c;
        logic [SEL_W-1:0] f;
        c = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            f = SEL_W'((k * mul + add) % NUM_IN);
            c[k*SEL_W +: SEL_W] = f;
        end
        return c;
    endfunction

    // This task pulses start and then streams words. Before a restart, the
    // words carry inverted data, so the second load must overwrite them.
    task automatic send_load(input logic [CFG_W-1:0] cfg, input bit gaps,
                             input int restart_after, input int stop_after, output bit ok);
        int w;
        int budget;
        bit restarted;
        bit v;
        bit hs;
        logic [WORD_W-1:0] word;
        w = 0; budget = 0; restarted = 0; ok = 1;
        io_cfg_start = 1'b1;
        @(negedge clk);
        io_cfg_start = 1'b0;
        while (w < stop_after) begin
            if (budget > 300) begin
                ok = 0;
                break;
            end
            budget++;
            if (!restarted && restart_after > 0 && w == restart_after) begin
                io_cfg_start = 1'b1;
                io_cfg_valid = 1'b1;
                io_cfg_data  = 8'h3C;
                @(negedge clk);
                io_cfg_start = 1'b0;
                w = 0;
                restarted = 1;
                continue;
            end
            v = gaps ? ($urandom_range(0, 1) != 0) : 1'b1;
            word = cfg[w*WORD_W +: WORD_W];
            io_cfg_valid = v;
            io_cfg_data  = (restart_after > 0 && !restarted) ? ~word : word;
            hs = v && io_cfg_ready;
            @(negedge clk);
            if (hs) begin
                w++;
                t_hs = cyc;
            end
        end
        io_cfg_valid = 1'b0;
    endtask

    // Cycle n = 1 is the cycle right after the final handshake edge. A commit
    // must show done in cycle NUM_OUT+1 and the new config one cycle later,
    // when busy has dropped.
    task automatic check_result(input int inject_n, input int idx);
        exp_t e;
        int done_cnt;
        int done_at;
        bit finished;
        int n;
        done_cnt = 0; done_at = 0; finished = 0;
        e = sb_q.pop_front();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            n = cyc - t_hs + 1;
            io_cfg_start = (inject_n != 0 && n == inject_n);
            if (io_cfg_done) begin
                done_cnt++;
                if (done_at == 0) done_at = n;
            end
            if (!io_busy) begin
                finished = 1;
                break;
            end
        end
        io_cfg_start = 1'b0;
        chk($sformatf("v%0d_back_to_idle", idx), CFG_W'(finished), CFG_W'(1));
        chk($sformatf("v%0d_done_pulses", idx), CFG_W'(done_cnt), CFG_W'(e.ok ? 1 : 0));
        if (e.ok) chk($sformatf("v%0d_done_latency", idx), CFG_W'(done_at), CFG_W'(NUM_OUT + 1));
        chk($sformatf("v%0d_err", idx), CFG_W'(io_cfg_err), CFG_W'(!e.ok));
        chk($sformatf("v%0d_mux", idx), io_mux_configs, e.mux);
    endtask

    task automatic check_after_reset(input string tag);
        int done_cnt;
        done_cnt = 0;
        chk({tag, "_mux"},   io_mux_configs, '0);
        chk({tag, "_busy"},  CFG_W'(io_busy), '0);
        chk({tag, "_ready"}, CFG_W'(io_cfg_ready), '0);
        chk({tag, "_err"},   CFG_W'(io_cfg_err), '0);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (io_cfg_done) done_cnt++;
        end
        chk({tag, "_no_done"}, CFG_W'(done_cnt), '0);
    endtask

    initial begin
        logic [CFG_W-1:0] c;
        exp_t e;
        bit ok;

        c = pattern(1, 0);
        vecs[0] = '{c, 1'b0, 0, 0, 1'b1};
        vecs[1] = '{pattern(0, 18), 1'b0, 0, 0, 1'b1};   // every field at the legal maximum
        vecs[2] = '{c, 1'b1, 0, 0, 1'b1};                 // same data, gappy valid
        c[23*SEL_W +: SEL_W] = 5'd19;
        vecs[3] = '{c, 1'b0, 0, 0, 1'b0};
        c = pattern(1, 0);
        c[0 +: SEL_W] = 5'd31;
        vecs[4] = '{c, 1'b1, 0, 0, 1'b0};
        vecs[5] = '{pattern(7, 3), 1'b0, 0, 10, 1'b1};    // start during CHECK is ignored
        vecs[6] = '{pattern(1, 5), 1'b1, 7, 0, 1'b1};     // restart after 7 words

        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_mux",   io_mux_configs, '0);
        chk("reset_ready", CFG_W'(io_cfg_ready), '0);
        chk("reset_done",  CFG_W'(io_cfg_done), '0);
        chk("reset_err",   CFG_W'(io_cfg_err), '0);
        chk("reset_busy",  CFG_W'(io_busy), '0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NVEC; i++) begin
            e.ok  = vecs[i].exp_ok;
            e.mux = vecs[i].exp_ok ? vecs[i].cfg : model_mux;
            model_mux = e.mux;
            sb_q.push_back(e);
            send_load(vecs[i].cfg, vecs[i].gaps, vecs[i].restart_after, NUM_WORDS, ok);
            if (!ok) begin
                total++;
                bad++;
                $display("FAIL v%0d_load_timeout: got stalled expected %0d words", i, NUM_WORDS);
                void'(sb_q.pop_front());
            end else begin
                check_result(vecs[i].inject_n, i);
            end
        end

        // Reset arriving together with word 10 abandons the load.
        send_load(pattern(3, 1), 1'b0, 0, 10, ok);
        io_cfg_valid = 1'b1;
        io_cfg_data  = 8'hA5;
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        io_cfg_valid = 1'b0;
        model_mux = '0;
        check_after_reset("rst_load");

        // Commit a legal configuration, then abandon the next load in CHECK.
        e.ok = 1'b1;
        e.mux = pattern(5, 2);
        model_mux = e.mux;
        sb_q.push_back(e);
        send_load(e.mux, 1'b0, 0, NUM_WORDS, ok);
        if (ok) check_result(0, 7);
        send_load(pattern(2, 7), 1'b0, 0, NUM_WORDS, ok);
        repeat (10) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_mux = '0;
        check_after_reset("rst_check");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
